// File: rtl/banked_mem_ctrl.sv
// Four-bank 16-bit word memory controller with per-bank busy timers and a
// two-stage registered read path.
module banked_mem_ctrl #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned BANK_CYCLES = 4,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [2:0]  BANK_LOAD = 3'(BANK_CYCLES);

  if (RD_LAT != 2) begin : g_bad_rd_lat
    $error("banked_mem_ctrl: read path is built for RD_LAT = 2");
  end
  if (BANK_CYCLES < 1 || BANK_CYCLES > 7) begin : g_bad_bank_cycles
    $error("banked_mem_ctrl: BANK_CYCLES must fit a 3-bit nonzero count");
  end

  logic [15:0]           mem [DEPTH];
  logic [2:0]            bank_cnt [4];
  logic [1:0]            bank;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  req_present;
  logic                  req_legal;
  logic                  accept;
  logic                  s1_valid;
  logic [15:0]           s1_data;

  assign bank        = addr[2:1];
  assign word_idx    = addr[DEPTH_LOG2:1];
  assign req_present = rd | wr;
  assign req_legal   = (rd ^ wr) & ~addr[0];

  // Upper address bits alias onto the same words and are deliberately dropped.
  if (DEPTH_LOG2 < 15) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[15:DEPTH_LOG2+1];
  end

  always_comb begin
    busy = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      busy[b] = (bank_cnt[b] != 3'd0);
    end
  end

  assign stall  = req_present & req_legal & busy[bank];
  assign accept = req_legal & ~busy[bank];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        bank_cnt[b] <= 3'd0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (accept && (bank == 2'(b))) begin
          bank_cnt[b] <= BANK_LOAD;
        end else if (bank_cnt[b] != 3'd0) begin
          bank_cnt[b] <= bank_cnt[b] - 3'd1;
        end
      end
    end
  end

  // Array is not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[word_idx] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= 16'h0000;
      data_out <= 16'h0000;
      err      <= 1'b0;
    end else begin
      s1_valid <= accept & rd;
      if (accept && rd) begin
        s1_data <= mem[word_idx];
      end
      data_out <= s1_valid ? s1_data : 16'h0000;
      err      <= req_present & ~req_legal;
    end
  end

endmodule

// File: doc/banked_mem_ctrl.md
BANKED_MEM_CTRL -- requirements
Module: banked_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 10, giving the log2 of the memory depth in 16-bit words.
REQ-002 The block SHALL have parameter BANK_CYCLES, default 4, giving the number of cycles a bank stays busy after an accepted access (range 1-7).
REQ-003 The block SHALL have parameter RD_LAT, fixed at 2, giving the number of cycles from read accept to valid data_out.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 addr  input  16  byte address; bank = addr[2:1]; word index = addr[DEPTH_LOG2:1].
REQ-007 data_in  input  16  write data.
REQ-008 wr  input  1  write request.
REQ-009 rd  input  1  read request.
REQ-010 data_out  output  16  read data.
REQ-011 stall  output  1  request not accepted this cycle; the requester SHALL hold addr, data_in, rd and wr.
REQ-012 busy  output  4  per-bank busy flags; bit b corresponds to bank b.
REQ-013 err  output  1  registered error flag for an illegal request.

Function
REQ-014 Request present: rd|wr. Legal request: exactly one of rd or wr is set and addr[0]=0.
REQ-015 stall SHALL be combinational: (rd|wr) & legal & busy[bank].
REQ-016 An accept occurs at a rising edge when a legal request is present and busy[bank]=0 in that cycle.
REQ-017 At most one access SHALL be accepted per cycle; there is no request queue.
REQ-018 Each bank SHALL have a 3-bit down-counter; on accept, the counter of the accessed bank loads BANK_CYCLES.
REQ-019 busy[b] SHALL equal (counter_b != 0), so busy[b] is high for exactly BANK_CYCLES cycles starting the cycle after accept.
REQ-020 A counter SHALL decrement each cycle while nonzero and saturate at 0.
REQ-021 Accesses to different banks on consecutive cycles SHALL be accepted back-to-back without stall.
REQ-022 Write: the array word at the word index SHALL be updated with data_in at the accept edge.
REQ-023 Read: the word SHALL be captured into pipeline stage 1 at the accept edge.
REQ-024 Stage 1 SHALL move to data_out at the next edge.
REQ-025 data_out SHALL be valid for exactly one cycle, RD_LAT=2 cycles after the accept edge, and SHALL be 16'h0000 in all other cycles.
REQ-026 A read accepted in the cycle after a write to the same word SHALL return the new data.
REQ-027 Address bits above DEPTH_LOG2 SHALL be ignored; the word index wraps modulo 2^DEPTH_LOG2.
REQ-028 Illegal request (rd&wr, or (rd|wr)&addr[0]): there SHALL be no array access and no busy change.
REQ-029 For an illegal request, stall SHALL be 0 and err SHALL be 1 for one cycle, the cycle after the edge that sampled it; otherwise err=0.
REQ-030 An illegal request held for N cycles SHALL produce err high for N cycles.
REQ-031 No request (rd=wr=0) SHALL produce no side effects, and counters continue to count down.

Reset
REQ-032 While rst=0: data_out=0, stall is driven by the combinational rule with busy=0 (so stall=0), busy=4'b0000, err=0, all counters=0, and the read pipeline is cleared.
REQ-033 Array contents SHALL NOT be affected by reset; a read of an unwritten word is unspecified.
REQ-034 Reset asserted mid-access SHALL discard any in-flight read (no data_out pulse after release) and clear busy immediately.
REQ-035 Deassertion is synchronised by the requester; the first accept can occur at the first rising edge with rst=1.

Verification
REQ-036 Write 16'hBEEF at addr 16'h0010, then read 16'h0010 on the next cycle -> write accepted with no stall; read stalls while busy[0]=1 and is accepted after 4 busy cycles; data_out=16'hBEEF exactly 2 cycles after the read accept.
REQ-037 Writes to addr 16'h0000, 0002, 0004, 0006 on 4 consecutive cycles -> no stall; busy goes 0001, 0011, 0111, 1111, then clears per bank in the same order.
REQ-038 Read addr 16'h0003 -> err=1 for one cycle, stall=0, busy unchanged, data_out stays 0; rd=wr=1 at addr 16'h0008 -> same response.
REQ-039 With DEPTH_LOG2=10, write 16'h1234 at addr 16'h0800, then read addr 16'h0000 -> data_out=16'h1234 (index wrap).
REQ-040 Read accepted at addr 16'h0002, rst pulsed low for one cycle after accept -> busy=0000 immediately, no data_out pulse follows, and the next legal request is accepted without stall.
